// File: rtl/sum_requester.sv
// Initiator for a start/valid adder responder: buffers operand pairs, issues them
// one at a time, and returns the sum with mismatch and timeout flags.
module sum_requester #(
  parameter int unsigned W       = 20,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  input  logic         valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_mismatch,
  output logic         res_timeout,
  output logic [7:0]   spurious_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [W-1:0]   mem_a [DEPTH];
  logic [W-1:0]   mem_b [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic           push;
  logic           pop;
  logic           spurious_hit;
  logic [W-1:0]   sum_ab;

  assign push   = op_valid && op_ready;
  assign pop    = (state == IDLE) && (count != '0);
  assign sum_ab = a + b;

  // A valid is only expected from the second WAIT edge onward.
  assign spurious_hit = valid && ((state == IDLE) || (state == HOLD) ||
                                  ((state == WAIT) && (timer == '0)));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Operand FIFO pointers and occupancy; op_ready tracks next-cycle fullness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      op_ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a;
      mem_b[wr_ptr] <= op_b;
    end
  end

  // Request/response sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      start        <= 1'b0;
      a            <= '0;
      b            <= '0;
      res_valid    <= 1'b0;
      res_sum      <= '0;
      res_mismatch <= 1'b0;
      res_timeout  <= 1'b0;
      spurious_cnt <= '0;
    end else begin
      if (spurious_hit && (spurious_cnt != 8'hFF))
        spurious_cnt <= spurious_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (count != '0) begin
            a     <= mem_a[rd_ptr];
            b     <= mem_b[rd_ptr];
            start <= 1'b1;
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          start <= 1'b0;
          if (valid && (timer != '0)) begin
            res_sum      <= y;
            res_mismatch <= (y != sum_ab);
            res_timeout  <= 1'b0;
            res_valid    <= 1'b1;
            state        <= HOLD;
          end else if ((timer + TW'(1)) == TW'(TIMEOUT)) begin
            res_sum      <= '0;
            res_mismatch <= 1'b0;
            res_timeout  <= 1'b1;
            res_valid    <= 1'b1;
            state        <= HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_requester.sv
// Directed bench for sum_requester with a behavioural one-cycle adder responder.
module tb_sum_requester;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [19:0] op_a;
  logic [19:0] op_b;
  logic        start;
  logic [19:0] a;
  logic [19:0] b;
  logic [19:0] y;
  logic        valid;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_sum;
  logic        res_mismatch;
  logic        res_timeout;
  logic [7:0]  spurious_cnt;

  sum_requester #(.W(20), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .start(start), .a(a), .b(b), .y(y),
    .valid(valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_mismatch(res_mismatch), .res_timeout(res_timeout),
    .spurious_cnt(spurious_cnt)
  );

  typedef struct {
    logic [19:0] va;
    logic [19:0] vb;
    int          mode;   // 0 correct, 1 sum+1, 2 silent
    logic [19:0] sum;
    logic        mm;
    logic        to;
    int          lat;
  } vec_t;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int start_cnt = 0;
  int dbl_start = 0;
  logic prev_start = 1'b0;
  int mode = 0;

  logic        pending;
  logic        resp_valid;
  logic [19:0] pend_y;
  logic [19:0] resp_y;
  logic        inj_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: sees start on the falling edge, answers one cycle later.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      resp_valid <= 1'b0;
      pend_y     <= '0;
      resp_y     <= '0;
    end else begin
      resp_valid <= pending && (mode != 2);
      resp_y     <= pend_y;
      pending    <= start;
      pend_y     <= a + b + ((mode == 1) ? 20'd1 : 20'd0);
    end
  end

  assign valid = resp_valid | inj_valid;
  assign y     = resp_y;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start) start_cnt <= start_cnt + 1;
    if (start && prev_start) dbl_start <= dbl_start + 1;
    prev_start <= start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic push_op(input logic [19:0] va, input logic [19:0] vb);
    op_valid = 1'b1;
    op_a     = va;
    op_b     = vb;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat, output bit got);
    int c0;
    c0  = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin
        got = 1'b1;
        lat = cyc - c0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    int s0;
    mode = v.mode;
    s0   = start_cnt;
    push_op(v.va, v.vb);
    wait_res(lat, got);
    check($sformatf("v%0d_got", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_sum", idx), 32'(res_sum), 32'(v.sum));
    check($sformatf("v%0d_mm", idx), 32'(res_mismatch), 32'(v.mm));
    check($sformatf("v%0d_to", idx), 32'(res_timeout), 32'(v.to));
    check($sformatf("v%0d_starts", idx), 32'(start_cnt - s0), 32'd1);
    handshake();
    check($sformatf("v%0d_drop", idx), 32'(res_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    bit seen;
    int s0;
    seen = 1'b0;
    s0   = start_cnt;
    repeat (n) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    check({name, "_nores"}, 32'(seen), 32'd0);
    check({name, "_nostart"}, 32'(start_cnt - s0), 32'd0);
  endtask

  vec_t vecs [7];
  logic [19:0] fill_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit got;
    vecs[0] = '{20'd5,     20'd7,     0, 20'd12,    1'b0, 1'b0, 3};
    vecs[1] = '{20'hFFFFF, 20'd3,     0, 20'd2,     1'b0, 1'b0, 3};
    vecs[2] = '{20'hFFFFF, 20'd3,     1, 20'd3,     1'b1, 1'b0, 3};
    vecs[3] = '{20'd5,     20'd7,     2, 20'd0,     1'b0, 1'b1, 9};
    vecs[4] = '{20'd100,   20'd200,   0, 20'd300,   1'b0, 1'b0, 3};
    vecs[5] = '{20'd0,     20'd0,     1, 20'd1,     1'b1, 1'b0, 3};
    vecs[6] = '{20'hAAAAA, 20'h55555, 0, 20'hFFFFF, 1'b0, 1'b0, 3};
    fill_exp = '{20'd3, 20'd11, 20'd22, 20'd33, 20'd44};

    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    inj_valid = 1'b0;
    #12;
    check("rst_start", 32'(start), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_sum", 32'(res_sum), 32'd0);
    check("rst_spur", 32'(spurious_cnt), 32'd0);
    check("rst_ab", 32'({a, b} != '0), 32'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_op_ready", 32'(op_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Fill while the first result is held under backpressure.
    mode = 0;
    push_op(20'd1, 20'd2);
    wait_res(lat, got);
    check("fill_first_got", 32'(got), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      push_op(20'(10 * i), 20'(i));
      check($sformatf("fill_op_ready_%0d", i), 32'(op_ready), 32'((i < 4) ? 1 : 0));
    end
    op_valid = 1'b1;
    op_a     = 20'd99;
    op_b     = 20'd1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    check("hold_valid", 32'(res_valid), 32'd1);
    check("hold_sum", 32'(res_sum), 32'd3);
    for (int i = 0; i < 5; i++) begin
      wait_res(lat, got);
      check($sformatf("drain%0d_got", i), 32'(got), 32'd1);
      check($sformatf("drain%0d_sum", i), 32'(res_sum), 32'(fill_exp[i]));
      handshake();
    end
    expect_quiet("drain_end", 12);
    check("drain_op_ready", 32'(op_ready), 32'd1);

    // Valids injected in IDLE only bump the saturating counter.
    check("spur_pre", 32'(spurious_cnt), 32'd0);
    inj_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("spur_100", 32'(spurious_cnt), 32'd100);
    repeat (200) @(posedge clk);
    #1;
    inj_valid = 1'b0;
    check("spur_sat", 32'(spurious_cnt), 32'd255);
    check("spur_no_res", 32'(res_valid), 32'd0);
    check("spur_no_start", 32'(start), 32'd0);
    run_vec(vecs[0], 10);
    check("spur_hold", 32'(spurious_cnt), 32'd255);

    // Reset while waiting with three ops queued.
    mode = 2;
    for (int i = 0; i < 4; i++) push_op(20'(i + 1), 20'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_spur", 32'(spurious_cnt), 32'd0);
    #2;
    rst_n = 1'b1;
    mode  = 0;
    @(posedge clk); #1;
    check("midrst_op_ready", 32'(op_ready), 32'd1);
    expect_quiet("midrst", 15);

    // Reset while start is high clears it immediately.
    push_op(20'd4, 20'd4);
    @(posedge clk); #1;
    check("startrst_pre", 32'(start), 32'd1);
    rst_n = 1'b0;
    #1;
    check("startrst_now", 32'(start), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_quiet("startrst", 12);
    run_vec(vecs[4], 11);

    check("no_double_start", 32'(dbl_start), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
